// File: rtl/ifetch_align.sv
// Instruction fetch aligner: turns halfword-aligned PC requests into 32-bit icache
// word fetches. Define IFETCH_RVC_EN for 16-bit instructions and the upper-half holding buffer.
module ifetch_align #(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_pc,
    output logic        cpu_ready,
    output logic [31:0] cpu_insn,
    output logic        cpu_compressed,
    output logic        cache_valid,
    output logic [31:0] cache_addr,
    input  logic        cache_ready,
    input  logic [31:0] cache_rdata
);

    typedef enum logic [2:0] {IDLE, FETCH_LO, GAP, FETCH_HI, RESP} state_t;

    state_t      state, state_d;
    logic        cv_d, rdy_d, cmp_d;
    logic [31:0] ca_d, insn_d;
    logic [2:0]  gap_cnt, gap_d;
    logic        abort_q, abort_d;
    logic        pend, pend_d;
    logic [15:0] lo_half, lo_d;
    logic        ack, rearm_ok, dropped;
    logic        unused_pc;

    assign ack       = cache_valid & cache_ready;
    // Counts down the icache rearm window that follows each accepted response.
    assign rearm_ok  = (gap_cnt <= 3'd1);
    assign dropped   = abort_q | ~cpu_valid;
    assign gap_d     = ack ? 3'(GAP_CYCLES) : ((gap_cnt != 3'd0) ? gap_cnt - 3'd1 : 3'd0);
    assign unused_pc = ^cpu_pc[1:0];

`ifdef IFETCH_RVC_EN
    logic        pc_hi, pc_hi_d;
    logic [15:0] buf_half, bh_d;
    logic [29:0] buf_tag, bt_d;
    logic        buf_vld, bv_d;
    logic [15:0] half;

    assign half = pc_hi ? cache_rdata[31:16] : cache_rdata[15:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_hi    <= 1'b0;
            buf_half <= '0;
            buf_tag  <= '0;
            buf_vld  <= 1'b0;
        end else begin
            pc_hi    <= pc_hi_d;
            buf_half <= bh_d;
            buf_tag  <= bt_d;
            buf_vld  <= bv_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cache_valid    <= 1'b0;
            cache_addr     <= '0;
            cpu_ready      <= 1'b0;
            cpu_insn       <= '0;
            cpu_compressed <= 1'b0;
            gap_cnt        <= '0;
            abort_q        <= 1'b0;
            pend           <= 1'b0;
            lo_half        <= '0;
        end else begin
            state          <= state_d;
            cache_valid    <= cv_d;
            cache_addr     <= ca_d;
            cpu_ready      <= rdy_d;
            cpu_insn       <= insn_d;
            cpu_compressed <= cmp_d;
            gap_cnt        <= gap_d;
            abort_q        <= abort_d;
            pend           <= pend_d;
            lo_half        <= lo_d;
        end
    end

    always_comb begin
        state_d = state;
        cv_d    = cache_valid;
        ca_d    = cache_addr;
        rdy_d   = 1'b0;
        insn_d  = cpu_insn;
        cmp_d   = cpu_compressed;
        abort_d = abort_q;
        pend_d  = pend;
        lo_d    = lo_half;
`ifdef IFETCH_RVC_EN
        pc_hi_d = pc_hi;
        bh_d    = buf_half;
        bt_d    = buf_tag;
        bv_d    = buf_vld;
`endif
        if (ack) begin
            cv_d = 1'b0;
`ifdef IFETCH_RVC_EN
            bh_d = cache_rdata[31:16];
            bt_d = cache_addr[31:2];
            bv_d = 1'b1;
`endif
        end

        case (state)
            IDLE: begin
                if (cpu_valid) begin
                    abort_d = 1'b0;
                    pend_d  = 1'b0;
                    ca_d    = {cpu_pc[31:2], 2'b00};
                    cv_d    = rearm_ok;
                    state_d = FETCH_LO;
`ifdef IFETCH_RVC_EN
                    pc_hi_d = cpu_pc[1];
                    if (cpu_pc[1] && buf_vld && buf_tag == cpu_pc[31:2]) begin
                        lo_d = buf_half;
                        cv_d = 1'b0;
                        if (buf_half[1:0] != 2'b11) begin
                            // Extra RESP cycle with cpu_ready low gives the 2-cycle hit latency.
                            insn_d  = {16'h0, buf_half};
                            cmp_d   = 1'b1;
                            pend_d  = 1'b1;
                            state_d = RESP;
                        end else begin
                            ca_d    = {cpu_pc[31:2] + 30'd1, 2'b00};
                            cv_d    = rearm_ok;
                            state_d = rearm_ok ? FETCH_HI : GAP;
                        end
                    end
`endif
                end
            end
            FETCH_LO, FETCH_HI: begin
                if (!cpu_valid) abort_d = 1'b1;
                if (!cache_valid) begin
                    if (dropped)       state_d = IDLE;
                    else if (rearm_ok) cv_d    = 1'b1;
                end else if (cache_ready) begin
                    if (dropped) begin
                        state_d = IDLE;
                    end else if (state == FETCH_HI) begin
                        insn_d  = {cache_rdata[15:0], lo_half};
                        cmp_d   = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = RESP;
                    end else begin
`ifdef IFETCH_RVC_EN
                        lo_d = half;
                        if (half[1:0] != 2'b11) begin
                            insn_d  = {16'h0, half};
                            cmp_d   = 1'b1;
                            rdy_d   = 1'b1;
                            state_d = RESP;
                        end else if (!pc_hi) begin
                            insn_d  = cache_rdata;
                            cmp_d   = 1'b0;
                            rdy_d   = 1'b1;
                            state_d = RESP;
                        end else begin
                            ca_d    = {cache_addr[31:2] + 30'd1, 2'b00};
                            state_d = GAP;
                        end
`else
                        insn_d  = cache_rdata;
                        cmp_d   = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = RESP;
`endif
                    end
                end
            end
            GAP: begin
                if (dropped) begin
                    state_d = IDLE;
                end else if (rearm_ok) begin
                    cv_d    = 1'b1;
                    state_d = FETCH_HI;
                end
            end
            RESP: begin
                if (pend) begin
                    rdy_d  = 1'b1;
                    pend_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
